// File: rtl/btb_assoc.sv
// N-way set-associative branch target buffer: combinational fetch-PC prediction,
// clocked update/allocation from resolved branches, 2-bit counters and tree pLRU.
module btb_assoc #(
    parameter int NUM_SETS = 8,
    parameter int NUM_WAYS = 2,
    parameter int ADDR_W   = 32
) (
    input  logic                                             clk,
    input  logic                                             rst,
    input  logic                                             lookup_en,
    input  logic [ADDR_W-1:0]                                lookup_pc,
    output logic                                             pred_hit,
    output logic                                             pred_taken,
    output logic [ADDR_W-1:0]                                pred_target,
    output logic [((NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1)-1:0] pred_way,
    input  logic                                             upd_en,
    input  logic [ADDR_W-1:0]                                upd_pc,
    input  logic                                             upd_taken,
    input  logic [ADDR_W-1:0]                                upd_target,
    input  logic                                             flush
);
    localparam int INDEX_W = $clog2(NUM_SETS);
    localparam int TAG_W   = ADDR_W - INDEX_W - 2;
    localparam int WAY_W   = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;

    logic [NUM_WAYS-1:0] r_valid  [NUM_SETS];
    logic [TAG_W-1:0]    r_tag    [NUM_SETS][NUM_WAYS];
    logic [ADDR_W-1:0]   r_target [NUM_SETS][NUM_WAYS];
    logic [1:0]          r_state  [NUM_SETS][NUM_WAYS];
    // Tree bits: [0] root, [1] left pair, [2] right pair; 2-way uses [0] only.
    logic [2:0]          r_plru   [NUM_SETS];

    logic [INDEX_W-1:0]  w_lk_idx, w_up_idx;
    logic [TAG_W-1:0]    w_lk_tag, w_up_tag;
    logic [NUM_WAYS-1:0] w_lk_match, w_up_match;
    logic                w_lk_hit, w_up_hit;
    logic [WAY_W-1:0]    w_lk_way, w_up_way, w_victim;
    logic                w_unused;

    assign w_lk_idx = lookup_pc[INDEX_W+1:2];
    assign w_lk_tag = lookup_pc[ADDR_W-1:INDEX_W+2];
    assign w_up_idx = upd_pc[INDEX_W+1:2];
    assign w_up_tag = upd_pc[ADDR_W-1:INDEX_W+2];
    assign w_unused = &{1'b0, lookup_pc[1:0], upd_pc[1:0]};

    function automatic logic [2:0] plru_touch(input logic [2:0] b, input logic [1:0] w);
        logic [2:0] n;
        n = b;
        if (NUM_WAYS == 4) begin
            n[0] = w[1];
            if (w[1]) n[2] = w[0];
            else      n[1] = w[0];
        end else if (NUM_WAYS == 2) begin
            n[0] = w[0];
        end
        return n;
    endfunction

    function automatic logic [1:0] plru_victim(input logic [2:0] b);
        logic [1:0] v;
        v = 2'b00;
        if (NUM_WAYS == 4) begin
            v[1] = ~b[0];
            v[0] = v[1] ? ~b[2] : ~b[1];
        end else if (NUM_WAYS == 2) begin
            v[0] = ~b[0];
        end
        return v;
    endfunction

    // Encoding 00 SNT, 01 WNT, 11 WT, 10 ST: the walk is a Gray-code ladder.
    function automatic logic [1:0] state_step(input logic [1:0] s, input logic taken);
        logic [1:0] n;
        n = s;
        if (taken) begin
            case (s)
                2'b00:   n = 2'b01;
                2'b01:   n = 2'b11;
                default: n = 2'b10;
            endcase
        end else begin
            case (s)
                2'b10:   n = 2'b11;
                2'b11:   n = 2'b01;
                default: n = 2'b00;
            endcase
        end
        return n;
    endfunction

    generate
        for (genvar gi = 0; gi < NUM_WAYS; gi++) begin : g_match
            assign w_lk_match[gi] = r_valid[w_lk_idx][gi] && (r_tag[w_lk_idx][gi] == w_lk_tag);
            assign w_up_match[gi] = r_valid[w_up_idx][gi] && (r_tag[w_up_idx][gi] == w_up_tag);
        end
    endgenerate

    // Descending scans so the lowest matching / lowest invalid way wins.
    always_comb begin
        w_lk_hit = |w_lk_match;
        w_up_hit = |w_up_match;
        w_lk_way = '0;
        w_up_way = '0;
        w_victim = WAY_W'(plru_victim(r_plru[w_up_idx]));
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            if (w_lk_match[w])           w_lk_way = WAY_W'(w);
            if (w_up_match[w])           w_up_way = WAY_W'(w);
            if (!r_valid[w_up_idx][w])   w_victim = WAY_W'(w);
        end
    end

    assign pred_hit    = !rst && w_lk_hit;
    assign pred_taken  = pred_hit && r_state[w_lk_idx][w_lk_way][1];
    assign pred_target = pred_hit ? r_target[w_lk_idx][w_lk_way] : '0;
    assign pred_way    = pred_hit ? w_lk_way : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < NUM_SETS; s++) begin
                r_valid[s] <= '0;
                r_plru[s]  <= '0;
                for (int w = 0; w < NUM_WAYS; w++) begin
                    r_tag[s][w]    <= '0;
                    r_target[s][w] <= '0;
                    r_state[s][w]  <= 2'b00;
                end
            end
        end else if (flush) begin
            for (int s = 0; s < NUM_SETS; s++) begin
                r_valid[s] <= '0;
            end
        end else begin
            if (lookup_en && w_lk_hit) begin
                r_plru[w_lk_idx] <= plru_touch(r_plru[w_lk_idx], 2'(w_lk_way));
            end
            // Update writes come later so they override a lookup touch of the same set.
            if (upd_en) begin
                if (w_up_hit) begin
                    r_state[w_up_idx][w_up_way] <= state_step(r_state[w_up_idx][w_up_way], upd_taken);
                    if (upd_taken) begin
                        r_target[w_up_idx][w_up_way] <= upd_target;
                    end
                    r_plru[w_up_idx] <= plru_touch(r_plru[w_up_idx], 2'(w_up_way));
                end else if (upd_taken) begin
                    r_valid[w_up_idx][w_victim]  <= 1'b1;
                    r_tag[w_up_idx][w_victim]    <= w_up_tag;
                    r_target[w_up_idx][w_victim] <= upd_target;
                    r_state[w_up_idx][w_victim]  <= 2'b11;
                    r_plru[w_up_idx]             <= plru_touch(r_plru[w_up_idx], 2'(w_victim));
                end
            end
        end
    end
endmodule

// File: doc/btb_assoc.md
Name: btb_assoc

Overview:
- Parametrised N-way set-associative branch target buffer with integrated storage, 2-bit dynamic predictors and tree-pLRU replacement.
- IF-stage port gives a same-cycle combinational prediction for the fetch PC.
- EX-stage port writes resolved branch outcomes back on the clock edge.
- Successor to the fixed 8-set/2-way lookup logic; adds update, allocation, flush and way/depth scaling.

Parameters:
- NUM_SETS, 8, number of sets; power of two, 2..256; INDEX_W = log2(NUM_SETS).
- NUM_WAYS, 2, ways per set; legal values 1, 2 or 4.
- ADDR_W, 32, PC/target width; TAG_W = ADDR_W - INDEX_W - 2.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- lookup_en  in  1  fetch lookup valid; qualifies pLRU touch only.
- lookup_pc  in  ADDR_W  fetch PC; index = pc[INDEX_W+1:2], tag = pc[ADDR_W-1:INDEX_W+2].
- pred_hit  out  1  valid entry with matching tag found.
- pred_taken  out  1  MSB of hit entry state; 0 on miss.
- pred_target  out  ADDR_W  target of hit way; 0 on miss.
- pred_way  out  max(1,log2(NUM_WAYS))  hit way index; 0 on miss.
- upd_en  in  1  resolved branch update valid.
- upd_pc  in  ADDR_W  PC of resolved branch.
- upd_taken  in  1  actual outcome.
- upd_target  in  ADDR_W  actual target.
- flush  in  1  invalidate all entries.

Behaviour:
- Entry fields: valid, tag[TAG_W], target[ADDR_W], state[2]. State encoding: 00 strong-not-taken, 01 weak-not-taken, 10 strong-taken, 11 weak-taken.
- Reset, one edge with rst=1: all valid=0, state=00, target=0, pLRU bits=0. While rst=1, pred_* are forced to 0. rst has priority over flush and update.
- Lookup is combinational, zero latency, and reads pre-edge storage. On a multi-way match, which is illegal, the lowest way wins.
- Lookup pLRU touch: on an edge with lookup_en=1 and pred_hit=1, the set's pLRU is marked with the hit way as most recently used.
- Update hit (valid and tag match in the upd set):
  - state moves one step. Taken: 00->01->11->10, 10 saturates. Not-taken: 10->11->01->00, 00 saturates.
  - target is written with upd_target only when upd_taken=1.
  - pLRU is touched with that way.
- Update miss with upd_taken=1: allocate the victim way with valid=1, tag, target=upd_target, state=11, and touch pLRU with it.
  - Victim is the lowest-index invalid way; otherwise the pLRU victim.
- Update miss with upd_taken=0: no change.
- pLRU convention (bits record the most-recently-used direction; victim is the opposite):
  - 2-way: one bit b = MRU way; victim = ~b.
  - 4-way: bits b0,b1,b2. Touching way w sets b0=w[1] and b[1+w[1]]=w[0]. Victim v[1]=~b0, v[0]=~b[1+v[1]].
  - 1-way: no pLRU; victim is always way 0.
- Same-edge lookup touch and update to the same set: the update's pLRU write wins. Different sets: both are applied.
- Same-cycle lookup and update to the same entry: the lookup returns old contents. New contents are visible from the next cycle; there is no bypass.
- flush=1 (rst=0): on the edge, all valid bits clear; state, target and pLRU are unchanged. Update in the same cycle is dropped.
- Index uses pc[1:0]-stripped bits. Tag comparison is full TAG_W.

Test Plan:
- Reset then lookup_pc=0x0000_0040 -> pred_hit=0, pred_taken=0, pred_target=0.
- Defaults. upd_en, pc=0x40, taken=1, target=0x100; next cycle lookup 0x40 -> hit=1, taken=1 (state 11), target=0x100, way=0.
- Defaults. Taken-update pc=0x40 three more times, then four not-taken updates -> state 11->10->10->10, then 11,01,00,00. pred_taken=1,1,1 then 1,0,0,0.
- 2-way, NUM_SETS=8. Allocate 0x40 (way0), then 0x240 (way1), lookup hit 0x40, then allocate 0x440 -> 0x440 replaces way1; 0x240 misses, 0x40 still hits.
- Same cycle lookup 0x40 and not-taken update 0x40 from state 11 -> lookup sees taken=1; the next cycle sees taken=0 (01).
- NUM_WAYS=4. Fill 4 ways of set 0, flush -> all lookups miss. Then update plus flush together -> entry not allocated.
